// File: rtl/ethernet_encapsulation.sv
// Transmit-side 802.3 framer: wraps a payload byte stream into
// preamble/SFD/DA/SA/length/payload/pad/FCS and drives GMII TX, then
// holds an inter-frame gap.
// Optional build macro: ETH_TX_FCS_INSERT_EN
//   defined   -> CRC-32 is computed and the 4-byte FCS is appended.
//   undefined -> no CRC logic, the frame ends after the last payload/pad
//                byte (for an external FCS inserter).
// Every GMII output is a register loaded from the byte belonging to the
// current state, so the line lags the FSM by one cycle. The first preamble
// byte is loaded directly from IDLE on the accepting edge, which is why
// PREAMBLE itself only spans six cycles.
`timescale 1ns/1ps
module ethernet_encapsulation #(
  parameter logic [47:0] destination_mac_addr = 48'h023528fbdd66,
  parameter logic [47:0] source_mac_addr      = 48'h072227acdb65,
  parameter int          MIN_PAYLOAD          = 46,
  parameter int          MAX_PAYLOAD          = 1500,
  parameter int          IFG_BYTES            = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [15:0] tx_len,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  gmii_data_out,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        busy,
  output logic        tx_done,
  output logic        len_err,
  output logic        underrun_err
);

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, SFD, DEST_MAC, SRC_MAC, LEN, PAYLOAD, PAD, FCS, IFG
  } state_t;

  state_t      state;
  state_t      state_next;
  state_t      after_data;
  logic [13:0] byte_count;
  logic [15:0] count_ext;
  logic [15:0] len_q;
  logic [15:0] pad_last;

  logic        accept;
  logic        reject;
  logic        underrun;
  logic        frame_end;
  logic [7:0]  emit_data;
  logic        emit_en;
  logic        emit_er;
  logic        done_p0;

  // Selects byte idx (0 = most significant) of a MAC address.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] sh;
    sh = mac << {idx, 3'b000};
    return sh[47:40];
  endfunction

`ifdef ETH_TX_FCS_INSERT_EN
  logic [31:0] crc;
  logic [31:0] fcs;
  logic        crc_en;

  // One byte of reflected CRC-32 (poly 0xEDB88320), LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign after_data = FCS;
  assign fcs        = ~crc;
  // DA through the last pad byte feed the CRC; an aborted byte does not.
  assign crc_en     = (state inside {DEST_MAC, SRC_MAC, LEN, PAYLOAD, PAD}) && !underrun;
`else
  assign after_data = IFG;
`endif

  assign count_ext = {2'b00, byte_count};
  assign pad_last  = 16'(MIN_PAYLOAD) - len_q - 16'd1;
  assign s_ready   = (state == PAYLOAD);
  assign busy      = (state != IDLE);
  assign frame_end = (state_next == IFG) && (state != IFG) && !underrun;

  // Next-state decision and the byte this state places on the line.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    underrun   = 1'b0;
    emit_data  = 8'h00;
    emit_en    = 1'b0;
    emit_er    = 1'b0;
    case (state)
      IDLE: begin
        if (tx_start) begin
          if (tx_len <= 16'(MAX_PAYLOAD)) begin
            accept     = 1'b1;
            state_next = PREAMBLE;
            emit_en    = 1'b1;
            emit_data  = 8'h55;
          end else begin
            reject = 1'b1;
          end
        end
      end
      PREAMBLE: begin
        emit_en   = 1'b1;
        emit_data = 8'h55;
        if (count_ext == 16'd5) state_next = SFD;
      end
      SFD: begin
        emit_en    = 1'b1;
        emit_data  = 8'hD5;
        state_next = DEST_MAC;
      end
      DEST_MAC: begin
        emit_en   = 1'b1;
        emit_data = mac_byte(destination_mac_addr, byte_count[2:0]);
        if (count_ext == 16'd5) state_next = SRC_MAC;
      end
      SRC_MAC: begin
        emit_en   = 1'b1;
        emit_data = mac_byte(source_mac_addr, byte_count[2:0]);
        if (count_ext == 16'd5) state_next = LEN;
      end
      LEN: begin
        emit_en   = 1'b1;
        emit_data = (byte_count == 14'd0) ? len_q[15:8] : len_q[7:0];
        if (count_ext == 16'd1) begin
          if (len_q != 16'd0)                   state_next = PAYLOAD;
          else if (len_q < 16'(MIN_PAYLOAD))    state_next = PAD;
          else                                  state_next = after_data;
        end
      end
      PAYLOAD: begin
        emit_en = 1'b1;
        if (s_valid) begin
          emit_data = s_data;
          if (count_ext == len_q - 16'd1) begin
            state_next = (len_q < 16'(MIN_PAYLOAD)) ? PAD : after_data;
          end
        end else begin
          emit_er    = 1'b1;
          underrun   = 1'b1;
          state_next = IFG;
        end
      end
      PAD: begin
        emit_en = 1'b1;
        if (count_ext == pad_last) state_next = after_data;
      end
`ifdef ETH_TX_FCS_INSERT_EN
      FCS: begin
        emit_en   = 1'b1;
        emit_data = fcs[{byte_count[1:0], 3'b000} +: 8];
        if (count_ext == 16'd3) state_next = IFG;
      end
`endif
      IFG: begin
        if (count_ext == 16'(IFG_BYTES - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, per-state byte counter and latched length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      byte_count <= 14'd0;
      len_q      <= 16'd0;
    end else begin
      state <= state_next;
      if (state_next != state)  byte_count <= 14'd0;
      else if (state != IDLE)   byte_count <= byte_count + 14'd1;
      if (accept) len_q <= tx_len;
    end
  end

  // ---- output stage p0: registered GMII byte and status pulses ----
  // Registers the current byte onto the line and raises the status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gmii_data_out <= 8'h00;
      gmii_tx_en    <= 1'b0;
      gmii_tx_er    <= 1'b0;
      len_err       <= 1'b0;
      underrun_err  <= 1'b0;
      done_p0       <= 1'b0;
      tx_done       <= 1'b0;
    end else begin
      gmii_data_out <= emit_data;
      gmii_tx_en    <= emit_en;
      gmii_tx_er    <= emit_er;
      len_err       <= reject;
      underrun_err  <= underrun;
      done_p0       <= frame_end;
      // ---- output stage p1: completion pulse, one cycle after the last byte ----
      tx_done       <= done_p0;
    end
  end

`ifdef ETH_TX_FCS_INSERT_EN
  // Running CRC over the bytes as they are driven; restarted per frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        crc <= 32'hFFFFFFFF;
    else if (accept) crc <= 32'hFFFFFFFF;
    else if (crc_en) crc <= crc32_byte(crc, emit_data);
  end
`endif

endmodule
